// File: rtl/muldiv_stall_ctrl.sv
// muldiv_stall_ctrl: sequences the multi-cycle mul/div unit, generates the HI/LO write strobe and the Decode hazard stalls
module muldiv_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic CLK,
  input  logic RST,
  input  logic START_E,
  input  logic DIV_START_E,
  input  logic SIGNED_E,
  input  logic hilo_read_D,
  input  logic md_start_D,
  input  logic abort,
  output logic mul_go,
  output logic div_go,
  output logic op_signed,
  output logic hilo_we,
  output logic hilo_sel_div,
  output logic md_busy,
  output logic StallF,
  output logic StallD,
  output logic FlushE,
  output logic md_overrun
);
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic hazard;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      cnt          <= '0;
      mul_go       <= 1'b0;
      div_go       <= 1'b0;
      hilo_sel_div <= 1'b0;
      op_signed    <= 1'b0;
      md_overrun   <= 1'b0;
    end else begin
      mul_go <= 1'b0;
      div_go <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        if ((START_E || DIV_START_E) && state != IDLE) md_overrun <= 1'b1;
        case (state)
          IDLE:
            if (DIV_START_E) begin
              state        <= DIV_RUN;
              cnt          <= CNT_W'(DIV_CYCLES - 1);
              div_go       <= 1'b1;
              hilo_sel_div <= 1'b1;
              op_signed    <= SIGNED_E;
              if (START_E) md_overrun <= 1'b1;
            end else if (START_E) begin
              state        <= MUL_RUN;
              cnt          <= CNT_W'(MUL_CYCLES - 1);
              mul_go       <= 1'b1;
              hilo_sel_div <= 1'b0;
              op_signed    <= SIGNED_E;
            end
          MUL_RUN, DIV_RUN:
            if (cnt == '0) state <= DONE;
            else cnt <= cnt - 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
  // a launch in Execute counts as busy so the Decode consumer stalls from that very cycle
  assign hazard  = (state != IDLE || START_E || DIV_START_E) && (hilo_read_D || md_start_D) && !abort;
  assign hilo_we = state == DONE && !abort;
  assign md_busy = state != IDLE;
  assign StallF  = hazard;
  assign StallD  = hazard;
  assign FlushE  = hazard;
endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// tb_muldiv_stall_ctrl: directed + random stimulus, per-cycle expectations queued for a separate monitor
module tb_muldiv_stall_ctrl;
  localparam int MC = 4;
  localparam int DC = 32;
  logic CLK = 1'b0;
  logic RST = 1'b0, START_E = 1'b0, DIV_START_E = 1'b0, SIGNED_E = 1'b0;
  logic hilo_read_D = 1'b0, md_start_D = 1'b0, abort = 1'b0;
  logic mul_go, div_go, op_signed, hilo_we, hilo_sel_div, md_busy, StallF, StallD, FlushE, md_overrun;
  int errors = 0, checks = 0;
  logic [9:0] exp_q[$];
  logic [1:0] hq[$];
  int len = 0, age = 0;
  bit m_div, m_sgn, m_ovr;
  string nm[10] = '{"mul_go", "div_go", "op_signed", "hilo_we", "hilo_sel_div", "md_busy", "StallF", "StallD", "FlushE", "md_overrun"};

  always #5 CLK = ~CLK;

  muldiv_stall_ctrl #(.MUL_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .START_E(START_E), .DIV_START_E(DIV_START_E), .SIGNED_E(SIGNED_E),
    .hilo_read_D(hilo_read_D), .md_start_D(md_start_D), .abort(abort),
    .mul_go(mul_go), .div_go(div_go), .op_signed(op_signed), .hilo_we(hilo_we),
    .hilo_sel_div(hilo_sel_div), .md_busy(md_busy), .StallF(StallF), .StallD(StallD),
    .FlushE(FlushE), .md_overrun(md_overrun)
  );

  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at t=%0t", n, a, e, $time);
    end
  endtask

  // model: an operation is "len cycles running then one write cycle", tracked by age since launch
  task automatic cyc(input bit st, dv, sg, hr, ms, ab, rs);
    bit busy, go, done, hz;
    START_E = st; DIV_START_E = dv; SIGNED_E = sg; hilo_read_D = hr; md_start_D = ms; abort = ab; RST = rs;
    busy = len != 0;
    go   = busy && age == 1;
    done = busy && age == len + 1;
    hz   = (busy || st || dv) && (hr || ms) && !ab;
    exp_q.push_back({go && !m_div, go && m_div, m_sgn, done && !ab, m_div, busy, hz, hz, hz, m_ovr});
    if (done && !ab) hq.push_back({m_div, m_sgn});
    @(posedge CLK);
    if (!rs) begin
      len = 0; m_div = 0; m_sgn = 0; m_ovr = 0;
    end else if (ab) begin
      len = 0;
    end else if (!busy) begin
      if (st || dv) begin
        len = dv ? DC : MC; age = 1; m_div = dv; m_sgn = sg;
        if (st && dv) m_ovr = 1;
      end
    end else begin
      if (st || dv) m_ovr = 1;
      if (done) len = 0;
      else age++;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit hr = 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, hr, 0, 0, 1);
  endtask

  initial begin : monitor
    logic [9:0] e, a;
    logic [1:0] h;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {mul_go, div_go, op_signed, hilo_we, hilo_sel_div, md_busy, StallF, StallD, FlushE, md_overrun};
        for (int i = 0; i < 10; i++) chk(nm[i], a[9-i], e[9-i]);
      end
      if (hilo_we === 1'b1) begin
        if (hq.size() == 0) chk("hilo_write_unexpected", 1'b1, 1'b0);
        else begin
          h = hq.pop_front();
          chk("hilo_write_sel_div", hilo_sel_div, h[1]);
          chk("hilo_write_signed", op_signed, h[0]);
        end
      end
    end
  end

  initial begin : stim
    @(posedge CLK); #1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 1, 0, 0, 0, 1); idle(8);
    cyc(0, 1, 0, 1, 0, 0, 1); idle(36, 1);
    cyc(1, 0, 0, 0, 0, 0, 1); idle(1); cyc(1, 0, 0, 0, 0, 0, 1); idle(6);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 1); idle(36);
    cyc(0, 1, 1, 1, 0, 0, 1); idle(9, 1); cyc(0, 0, 0, 1, 0, 1, 1); idle(30, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1); idle(2); cyc(0, 0, 0, 0, 0, 0, 0); idle(2);
    cyc(1, 0, 1, 0, 0, 0, 1); idle(8);
    cyc(1, 0, 0, 0, 0, 1, 1); idle(3);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0, 1'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 149) != 0);
    idle(3);
    @(negedge CLK);
    chk("hilo_writes_drained", hq.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
